// File: rtl/pwm_fade_sequencer_if.sv
// Host configuration channel of the PWM fade sequencer.
// Uses a valid/ready handshake that selects one channel's target and step.
interface pwm_fade_sequencer_if #(
  parameter int COMPARE_SIZE = 8,
  parameter int NUM_CH       = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CH_W-1:0]         cfg_ch;
  logic [COMPARE_SIZE-1:0] cfg_target;
  logic [COMPARE_SIZE-1:0] cfg_step;

  modport master (output cfg_valid, cfg_ch, cfg_target, cfg_step, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_target, cfg_step, output cfg_ready);
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Steps NUM_CH PWM compare values toward host targets once per prescaler tick.
// Defining PWM_FADE_IRQ_EN adds per-channel done flags and an irq output.
module pwm_fade_sequencer #(
  parameter int COMPARE_SIZE = 8,
  parameter int NUM_CH       = 4,
  parameter int PRESCALE_W   = 16
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [PRESCALE_W-1:0]   prescale_in,
  pwm_fade_sequencer_if.slave     cfg,
  output logic [COMPARE_SIZE-1:0] pwm_compare,
  output logic [NUM_CH-1:0]       pwm_wr,
  output logic                    busy,
  output logic                    tick_overrun
`ifdef PWM_FADE_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH-1:0]       done_status,
  output logic                    irq
`endif
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [CH_W-1:0]         ch_idx_r, ch_idx_s;
  logic [PRESCALE_W-1:0]   presc_r;
  logic                    tick_s, tick_pend_r, pend_clr_s, upd_s, last_ch_s, cfg_hs_s;
  logic [COMPARE_SIZE-1:0] target_r  [NUM_CH];
  logic [COMPARE_SIZE-1:0] step_r    [NUM_CH];
  logic [COMPARE_SIZE-1:0] current_r [NUM_CH];
  logic [COMPARE_SIZE-1:0] nxt_duty_s, pwm_compare_r;
  logic [NUM_CH-1:0]       wr_s, pwm_wr_r;
  logic                    busy_r, cfg_ready_r, tick_overrun_r;

  // Saturating move of cur toward tgt by stp; stp==0 jumps straight to tgt.
  function automatic logic [COMPARE_SIZE-1:0] next_duty(
    input logic [COMPARE_SIZE-1:0] cur,
    input logic [COMPARE_SIZE-1:0] tgt,
    input logic [COMPARE_SIZE-1:0] stp
  );
    logic [COMPARE_SIZE-1:0] diff;
    next_duty = tgt;
    if (tgt > cur) begin
      diff = tgt - cur;
      if ((stp != '0) && (diff > stp)) next_duty = cur + stp;
      else next_duty = tgt;
    end else begin
      diff = cur - tgt;
      if ((stp != '0) && (diff > stp)) next_duty = cur - stp;
      else next_duty = tgt;
    end
  endfunction

  assign tick_s     = en && (presc_r == prescale_in);
  assign cfg_hs_s   = cfg.cfg_valid && cfg_ready_r;
  assign last_ch_s  = (ch_idx_r == LAST_CH);
  assign nxt_duty_s = next_duty(current_r[ch_idx_r], target_r[ch_idx_r], step_r[ch_idx_r]);

  // Prescaler and tick bookkeeping; a tick landing on a pending tick is an overrun.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      presc_r        <= '0;
      tick_pend_r    <= 1'b0;
      tick_overrun_r <= 1'b0;
    end else begin
      if (!en || tick_s) presc_r <= '0;
      else presc_r <= presc_r + 1'b1;
      if (tick_s) tick_pend_r <= 1'b1;
      else if (pend_clr_s) tick_pend_r <= 1'b0;
      else tick_pend_r <= tick_pend_r;
      if (tick_s && tick_pend_r) tick_overrun_r <= 1'b1;
      else tick_overrun_r <= tick_overrun_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) state_r <= IDLE;
    else state_r <= state_s;
  end

  // Next-state logic; wr_s is the one-hot strobe for the coming WRITE cycle.
  always_comb begin
    state_s    = state_r;
    ch_idx_s   = ch_idx_r;
    pend_clr_s = 1'b0;
    upd_s      = 1'b0;
    wr_s       = '0;
    case (state_r)
      IDLE: begin
        if (tick_pend_r) begin
          pend_clr_s = 1'b1;
          ch_idx_s   = '0;
          state_s    = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (current_r[ch_idx_r] != target_r[ch_idx_r]) begin
          upd_s          = 1'b1;
          wr_s[ch_idx_r] = 1'b1;
          state_s        = WRITE;
        end else if (last_ch_s) begin
          state_s = IDLE;
        end else begin
          ch_idx_s = ch_idx_r + 1'b1;
        end
      end
      WRITE: state_s = RELEASE;
      RELEASE: begin
        if (last_ch_s) begin
          state_s = IDLE;
        end else begin
          ch_idx_s = ch_idx_r + 1'b1;
          state_s  = SCAN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Channel arrays and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ch_idx_r      <= '0;
      pwm_compare_r <= '0;
      pwm_wr_r      <= '0;
      busy_r        <= 1'b0;
      cfg_ready_r   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_r[i]  <= '0;
        step_r[i]    <= '0;
        current_r[i] <= '0;
      end
    end else begin
      ch_idx_r    <= ch_idx_s;
      pwm_wr_r    <= wr_s;
      busy_r      <= (state_s != IDLE);
      cfg_ready_r <= (state_s == IDLE);
      if (upd_s) begin
        current_r[ch_idx_r] <= nxt_duty_s;
        pwm_compare_r       <= nxt_duty_s;
      end
      if (cfg_hs_s && ({1'b0, cfg.cfg_ch} < NUM_CH_V)) begin
        target_r[cfg.cfg_ch] <= cfg.cfg_target;
        step_r[cfg.cfg_ch]   <= cfg.cfg_step;
      end
    end
  end

  assign pwm_compare   = pwm_compare_r;
  assign pwm_wr        = pwm_wr_r;
  assign busy          = busy_r;
  assign tick_overrun  = tick_overrun_r;
  assign cfg.cfg_ready = cfg_ready_r;

`ifdef PWM_FADE_IRQ_EN
  logic [NUM_CH-1:0] done_r, done_s;
  logic              irq_r;

  // A write landing on target sets the flag; same-cycle clear loses.
  always_comb begin
    done_s = done_r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pwm_wr_r[i] && (pwm_compare_r == target_r[i])) done_s[i] = 1'b1;
      else if (irq_clr[i]) done_s[i] = 1'b0;
      else done_s[i] = done_r[i];
    end
  end

  // Done flag and irq registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      done_r <= '0;
      irq_r  <= 1'b0;
    end else begin
      done_r <= done_s;
      irq_r  <= |done_s;
    end
  end

  assign done_status = done_r;
  assign irq         = irq_r;
`endif
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized configs checked write-by-write against a duty-stepping model.
module tb_pwm_fade_sequencer;
  localparam int CS  = 8;
  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int LOGN = 4096;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] prescale_in = '0;
  logic [CS-1:0] pwm_compare;
  logic [NCH-1:0] pwm_wr;
  logic          busy, tick_overrun;

  pwm_fade_sequencer_if #(.COMPARE_SIZE(CS), .NUM_CH(NCH)) cfg_bus ();
`ifdef PWM_FADE_IRQ_EN
  logic [NCH-1:0] irq_clr = '0;
  logic [NCH-1:0] done_status;
  logic           irq;
`endif

  pwm_fade_sequencer #(.COMPARE_SIZE(CS), .NUM_CH(NCH), .PRESCALE_W(PW)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .en           (en),
    .prescale_in  (prescale_in),
    .cfg          (cfg_bus),
    .pwm_compare  (pwm_compare),
    .pwm_wr       (pwm_wr),
    .busy         (busy),
    .tick_overrun (tick_overrun)
`ifdef PWM_FADE_IRQ_EN
    ,
    .irq_clr      (irq_clr),
    .done_status  (done_status),
    .irq          (irq)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]      ch;
    logic [7:0]      tgt;
    logic [7:0]      stp;
    logic [2:0]      n;
    logic [3:0][7:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcur [NCH];
  int mtgt [NCH];
  int mstp [NCH];
  int last_bus = 0;
  logic [NCH-1:0] prev_wr = '0;
  bit mon_on = 1'b0;
  int log_ch [LOGN];
  int log_val [LOGN];
  int log_cyc [LOGN];
  int wr_cnt = 0;
  int rd_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_next(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= stp) ? tgt : cur + stp;
    if (tgt < cur) return (cur - tgt <= stp) ? tgt : cur - stp;
    return tgt;
  endfunction

  // Called at each falling edge: checks strobes against the model and tracks config/reset.
  task automatic observe();
    int ch;
    cyc++;
    if (mon_on) begin
      if (pwm_wr != '0) begin
        chk("wr_onehot", $countones(pwm_wr), 1);
        chk("wr_back_to_back", int'(prev_wr), 0);
        ch = 0;
        for (int i = 0; i < NCH; i++) if (pwm_wr[i]) ch = i;
        chk("wr_value", int'(pwm_compare), model_next(mcur[ch], mtgt[ch], mstp[ch]));
        mcur[ch] = int'(pwm_compare);
        last_bus = int'(pwm_compare);
        log_ch[wr_cnt % LOGN]  = ch;
        log_val[wr_cnt % LOGN] = int'(pwm_compare);
        log_cyc[wr_cnt % LOGN] = cyc;
        wr_cnt++;
      end else begin
        chk("bus_hold", int'(pwm_compare), last_bus);
      end
    end
    prev_wr = pwm_wr;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        mcur[i] = 0; mtgt[i] = 0; mstp[i] = 0;
      end
      last_bus = 0;
      prev_wr = '0;
    end else if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) begin
      mtgt[int'(cfg_bus.cfg_ch)] = int'(cfg_bus.cfg_target);
      mstp[int'(cfg_bus.cfg_ch)] = int'(cfg_bus.cfg_step);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    observe();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_cfg(input int ch, input int tgt, input int stp);
    bit acc;
    acc = 1'b0;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_ch     = 2'(ch);
    cfg_bus.cfg_target = 8'(tgt);
    cfg_bus.cfg_step   = 8'(stp);
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = cfg_bus.cfg_ready;
      step();
    end
    chk("cfg_accept", int'(acc), 1);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_write(output bit got, output int ch, output int val, output int wc);
    got = 1'b0; ch = -1; val = -1; wc = 0;
    for (int i = 0; i < 60 && wr_cnt == rd_idx; i++) step();
    if (wr_cnt > rd_idx) begin
      got = 1'b1;
      ch  = log_ch[rd_idx % LOGN];
      val = log_val[rd_idx % LOGN];
      wc  = log_cyc[rd_idx % LOGN];
      rd_idx++;
    end
  endtask

  task automatic converge(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = 1'b1;
      for (int c = 0; c < NCH; c++) if (mcur[c] != mtgt[c]) done = 1'b0;
    end
    for (int c = 0; c < NCH; c++) chk(tag, mcur[c], mtgt[c]);
  endtask

  vec_t vecs [9];

  initial begin
    bit got, hit;
    int ch, val, wc, pc, start, wc1, c, t, s;

    vecs[0] = '{ch: 2'd0, tgt: 8'd200, stp: 8'd50,  n: 3'd4, exp: {8'd200, 8'd150, 8'd100, 8'd50}};
    vecs[1] = '{ch: 2'd1, tgt: 8'd200, stp: 8'd0,   n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd200}};
    vecs[2] = '{ch: 2'd1, tgt: 8'd10,  stp: 8'd64,  n: 3'd3, exp: {8'd0, 8'd10, 8'd72, 8'd136}};
    vecs[3] = '{ch: 2'd2, tgt: 8'd255, stp: 8'd0,   n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd255}};
    vecs[4] = '{ch: 2'd3, tgt: 8'd0,   stp: 8'd7,   n: 3'd0, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{ch: 2'd3, tgt: 8'd255, stp: 8'd200, n: 3'd2, exp: {8'd0, 8'd0, 8'd255, 8'd200}};
    vecs[6] = '{ch: 2'd3, tgt: 8'd0,   stp: 8'd255, n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[7] = '{ch: 2'd0, tgt: 8'd199, stp: 8'd5,   n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd199}};
    vecs[8] = '{ch: 2'd2, tgt: 8'd3,   stp: 8'd100, n: 3'd3, exp: {8'd0, 8'd3, 8'd55, 8'd155}};

    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_target = '0; cfg_bus.cfg_step = '0;
    for (int i = 0; i < NCH; i++) begin mcur[i] = 0; mtgt[i] = 0; mstp[i] = 0; end

    // Reset values
    @(posedge sys_clk); #1;
    mon_on = 1'b1;
    chk("rst_cfg_ready", int'(cfg_bus.cfg_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pwm_wr", int'(pwm_wr), 0);
    chk("rst_compare", int'(pwm_compare), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_cfg_ready", int'(cfg_bus.cfg_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Directed vector table, one channel fading per entry, tick every 10 cycles
    prescale_in = 16'd9;
    en = 1'b1;
    for (int v = 0; v < 9; v++) begin
      rd_idx = wr_cnt;
      do_cfg(int'(vecs[v].ch), int'(vecs[v].tgt), int'(vecs[v].stp));
      pc = 0;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        wait_write(got, ch, val, wc);
        chk("vec_write_seen", int'(got), 1);
        if (got) begin
          chk("vec_ch", ch, int'(vecs[v].ch));
          chk("vec_val", val, int'(vecs[v].exp[k]));
          if (k > 0) chk("vec_spacing", wc - pc, 10);
          pc = wc;
        end
      end
      repeat (25) step();
      chk("vec_quiet", wr_cnt - rd_idx, 0);
    end

    // Two channels changing on one tick: ch0 then ch3, latency from enable
    en = 1'b0;
    repeat (20) step();
    do_cfg(0, 150, 0);
    do_cfg(3, 77, 0);
    rd_idx = wr_cnt;
    start = cyc;
    en = 1'b1;
    wait_write(got, ch, val, wc1);
    chk("multi_first_ch", ch, 0);
    chk("multi_first_val", val, 150);
    chk("tick_latency", wc1 - start, 13);
    wait_write(got, ch, val, wc);
    chk("multi_second_ch", ch, 3);
    chk("multi_second_val", val, 77);
    chk("multi_gap", wc - wc1, 5);

    // Tick every cycle with all channels fading: overrun sticks, fades converge
    en = 1'b0;
    repeat (20) step();
    chk("overrun_clear", int'(tick_overrun), 0);
    do_cfg(0, 10, 9);
    do_cfg(1, 250, 11);
    do_cfg(2, 60, 4);
    do_cfg(3, 33, 2);
    prescale_in = 16'd0;
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin step(); hit = tick_overrun; end
    chk("overrun_set", int'(hit), 1);
    converge(3000, "overrun_converge");
    chk("overrun_sticky", int'(tick_overrun), 1);

    // Reset asserted during the WRITE cycle of ch1
    en = 1'b0;
    prescale_in = 16'd9;
    repeat (20) step();
    do_cfg(1, 100, 0);
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin step(); hit = pwm_wr[1]; end
    chk("rst_write_seen", int'(hit), 1);
    rst_n = 1'b0;
    step();
    chk("midrst_pwm_wr", int'(pwm_wr), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_compare", int'(pwm_compare), 0);
    chk("midrst_cfg_ready", int'(cfg_bus.cfg_ready), 0);
    chk("midrst_overrun", int'(tick_overrun), 0);
    rst_n = 1'b1;
    step();
    chk("midrst_ready_back", int'(cfg_bus.cfg_ready), 1);
    rd_idx = wr_cnt;
    repeat (40) step();
    chk("midrst_no_write", wr_cnt - rd_idx, 0);
    do_cfg(1, 5, 0);
    wait_write(got, ch, val, wc);
    chk("reconf_ch", ch, 1);
    chk("reconf_val", val, 5);

    // Randomized configs and prescaler changes, every write checked by observe()
    prescale_in = 16'd5;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat (3) step();
        prescale_in = PW'($urandom_range(0, 20));
        en = 1'b1;
      end else begin
        c = int'($urandom_range(0, NCH - 1));
        t = int'($urandom_range(0, 255));
        s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80));
        do_cfg(c, t, s);
      end
      repeat ($urandom_range(0, 30)) step();
    end
    en = 1'b1;
    converge(8000, "random_converge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Controller that owns the compare-register write path of NUM_CH PWM generator channels. It holds a per-channel target duty and step size, and current duty, and on every prescaler tick moves each channel's duty toward its target. Updated duties go out as wr-strobed writes on a shared compare bus. It sits between the host register interface and the PWM generator instances and provides glitch-free hardware fades.

Parameters:
COMPARE_SIZE, 8, width of duty/compare values
NUM_CH, 4, number of PWM channels sequenced (1..16)
PRESCALE_W, 16, width of fade-tick prescaler

Ports:
sys_clk  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
en  in  1  fade engine enable; low holds prescaler at 0
prescale_in  in  PRESCALE_W  tick period minus one, sampled live
cfg_valid  in  1  host config request
cfg_ready  out  1  config accepted when valid&ready
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index
cfg_target  in  COMPARE_SIZE  requested final duty
cfg_step  in  COMPARE_SIZE  duty change per tick; 0 = jump immediately
pwm_compare  out  COMPARE_SIZE  shared compare bus to all channels
pwm_wr  out  NUM_CH  one-hot write strobe per channel
busy  out  1  high whenever FSM not in IDLE
tick_overrun  out  1  sticky: tick arrived while previous tick still pending

Behaviour:
- Reset: all outputs 0 (cfg_ready 0 during reset cycle, 1 in first IDLE cycle after), target/step/current arrays 0, prescaler 0, tick_pend 0, FSM IDLE.
- Decided: reset rst_n, synchronous, active-low; clock sys_clk.
- Prescaler: counts 0..prescale_in while en=1; at count==prescale_in, asserts internal tick, reloads 0. prescale_in=0 -> tick every cycle. en=0 -> counter held 0, no ticks; an in-flight sequence still completes.
- tick sets tick_pend. tick while tick_pend already 1 -> tick_overrun set (cleared only by reset); ticks do not accumulate.
- cfg_ready = (state==IDLE). On handshake: target[cfg_ch]<=cfg_target, step[cfg_ch]<=cfg_step; current unchanged. cfg_ch>=NUM_CH ignored but still handshaken. Config and tick in same cycle: both take effect; the scan uses the new target.
- FSM states IDLE, SCAN, WRITE, RELEASE:
  - IDLE: if tick_pend -> clear tick_pend, ch_idx<=0, go SCAN.
  - SCAN (one cycle per channel): if current[ch]!=target[ch] -> compute next, current[ch]<=next, pwm_compare<=next, go WRITE; else if ch_idx==NUM_CH-1 -> IDLE, else ch_idx+1, stay SCAN.
  - WRITE: pwm_wr[ch_idx]=1 for exactly one cycle; pwm_compare stable. -> RELEASE.
  - RELEASE: pwm_wr all 0 for one cycle (re-arms generator's once-per-strobe latch); if last channel -> IDLE else ch_idx+1 -> SCAN.
- Latency: tick_pend set in cycle T -> SCAN ch0 at T+1 -> pwm_wr[0] high at T+2 if ch0 changes.
- Step arithmetic (unsigned, no wrap): up: next = (step==0 || target-current<=step) ? target : current+step; down symmetric with current-step. Never overshoots; never wraps past 0 or 2^COMPARE_SIZE-1.
- pwm_compare holds last written value between writes; at most one pwm_wr bit high in any cycle; pwm_wr never high two consecutive cycles.
- Reset mid-sequence: FSM to IDLE next cycle, pwm_wr 0, all state cleared; no partial write.

Optional Feature:
PWM_FADE_IRQ_EN: adds ports irq_clr (in, NUM_CH, write-1-to-clear), done_status (out, NUM_CH) and irq (out, 1). done_status[ch] set in the WRITE cycle where the written value equals target[ch]. Clear and set in same cycle: set wins. irq = |done_status. Without macro: ports and logic absent; no other behaviour changes.

Test Plan:
- Reset then cfg ch0 target=200 step=50, prescale_in=9, en=1 -> ch0 writes 50,100,150,200 on successive ticks, 10 cycles apart; then no further pwm_wr.
- ch1 current 200, cfg target=10 step=64 -> writes 136,72,10; no underflow, then idle.
- cfg ch2 target=255 step=0 -> single write of 255 on next tick.
- ch0 and ch3 both changing on one tick -> pwm_wr[0] then pwm_wr[3], each one cycle high, separated by at least one low cycle; pwm_compare matches each strobe.
- prescale_in=0 with NUM_CH=4 all channels fading -> tick_overrun goes 1 and stays 1; fades still converge.
- Assert rst_n=0 during WRITE of ch1 -> next cycle pwm_wr=0, busy=0, pwm_compare=0; a later tick produces no write until reconfigured.
